// File: rtl/ram_port_bridge.sv
// Bridges the sd_host RAM master strobes onto a valid/ready memory request channel
// through an ordered request FIFO, returns read data, and throttles the host with STOP.
module ram_port_bridge #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              rst_L,
  input  logic [63:0]       host_addr,
  input  logic              host_rd_en,
  input  logic              host_wr_en,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              host_stop,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic [3:0]        err_status,
  input  logic              err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] STOP_TH  = CW'(DEPTH - 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  // Control state is fully implied by count/rd_pend; kept explicit for coverage.
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_RD} state_e;

  req_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_pend_q, rd_pend_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          stop_q, stop_d;
  logic [3:0]    err_q, err_d;
  state_e        state_q, state_d;

  logic          in_range, one_strobe, full, push, pop, rsp_ok;
  logic [3:0]    err_set;
  req_t          head;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default is how latches get inferred.
  always_comb begin
    in_range   = (host_addr >> ADDR_W) == 64'd0;
    one_strobe = host_rd_en ^ host_wr_en;
    full       = (count_q == FULL_CNT);
    push       = one_strobe & in_range & ~full;
    pop        = mem_req_valid & mem_req_ready;
    rsp_ok     = mem_rsp_valid & (rd_pend_q != '0);

    count_d    = count_q + CW'(push) - CW'(pop);
    rd_pend_d  = rd_pend_q + CW'(push & host_rd_en) - CW'(rsp_ok);
    rdata_d    = rsp_ok ? mem_rsp_data : rdata_q;

    err_set    = {mem_rsp_valid & (rd_pend_q == '0),
                  one_strobe & in_range & full,
                  (host_rd_en | host_wr_en) & ~in_range,
                  host_rd_en & host_wr_en};
    // A set in the clearing cycle survives the clear.
    err_d      = (err_clr ? 4'b0000 : err_q) | err_set;

    stop_d     = (count_d >= STOP_TH) | (rd_pend_d != '0);
  end

  always_comb begin
    state_d = IDLE;
    if (count_d != '0)        state_d = BUSY;
    else if (rd_pend_d != '0) state_d = WAIT_RD;
  end

  always_comb begin
    mem_req_valid = 1'b0;
    if (state_q == BUSY) mem_req_valid = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= '0;
      rdata_q   <= '0;
      stop_q    <= 1'b1;
      err_q     <= '0;
      state_q   <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  // NOTE: the FIFO storage has no reset; an empty FIFO never presents stale
  // entries, so clearing the array would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{we:    host_wr_en,
                            addr:  host_addr[ADDR_W-1:0],
                            wdata: host_wr_en ? host_wdata : 32'd0};
    end
  end

  assign head          = fifo_q[rd_ptr_q];
  assign mem_req_we    = head.we;
  assign mem_req_addr  = head.addr;
  assign mem_req_wdata = head.wdata;
  assign host_rdata    = rdata_q;
  assign host_stop     = stop_q;
  assign err_status    = err_q;

endmodule

// File: tb/tb_ram_port_bridge.sv
// Scoreboard bench for ram_port_bridge: a cycle-level behavioural model predicts accepted
// requests, STOP, read data and error flags; a negedge monitor compares the DUT against it.
module tb_ram_port_bridge;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        rst_L = 1'b1;
  logic [63:0] host_addr = '0;
  logic        host_rd_en = 1'b0, host_wr_en = 1'b0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;
  logic        host_stop;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [3:0]  err_status;
  logic        err_clr = 1'b0;

  always #5 CLK = ~CLK;

  ram_port_bridge #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .CLK(CLK), .rst_L(rst_L),
    .host_addr(host_addr), .host_rd_en(host_rd_en), .host_wr_en(host_wr_en),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_stop(host_stop),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_status(err_status), .err_clr(err_clr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_req[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  // Model state: what the bridge should hold after the most recent clock edge.
  int          m_cnt = 0, m_pend = 0, mem_out = 0;
  logic [3:0]  m_err = '0;
  logic        m_stop = 1'b1;
  logic [31:0] m_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; mem_out = 0;
    m_err = '0; m_stop = 1'b1; m_rdata = '0;
    exp_req.delete();
  endtask

  // Present one cycle of host/memory inputs, let the edge happen, then advance the model.
  task automatic step(input logic rd, input logic wr, input logic [63:0] addr,
                      input logic [31:0] wd, input logic rdy, input logic rv,
                      input logic [31:0] rdat, input logic clr);
    logic       rng, one, acc;
    logic [3:0] set;
    host_rd_en = rd; host_wr_en = wr; host_addr = addr; host_wdata = wd;
    mem_req_ready = rdy; mem_rsp_valid = rv; mem_rsp_data = rdat; err_clr = clr;
    @(posedge CLK);
    #1;
    rng = (addr[63:32] == 32'd0);
    one = rd ^ wr;
    acc = one && rng && (m_cnt < DEPTH);
    set = {rv && (m_pend == 0), one && rng && (m_cnt == DEPTH), (rd || wr) && !rng, rd && wr};
    if (m_cnt != 0 && rdy) m_cnt--;
    if (acc) begin
      m_cnt++;
      exp_req.push_back('{we: wr, addr: addr[31:0], wdata: wr ? wd : 32'd0});
    end
    if (rv && m_pend > 0) begin
      m_pend--;
      m_rdata = rdat;
    end
    if (acc && rd) m_pend++;
    m_err  = (clr ? 4'b0000 : m_err) | set;
    m_stop = (m_cnt >= DEPTH - 1) || (m_pend != 0);
    host_rd_en = 1'b0; host_wr_en = 1'b0; mem_rsp_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 0, 64'd0, 32'd0, rdy, 0, 32'd0, 0);
  endtask

  // Run with ready high and answer every read until the model is empty, bounded.
  task automatic drain();
    logic rv;
    for (int i = 0; i < 200 && (m_cnt != 0 || m_pend != 0); i++) begin
      rv = (mem_out > 0);
      if (rv) mem_out--;
      step(0, 0, 64'd0, 32'd0, 1, rv, $urandom, 0);
    end
    check("drain_bound", (m_cnt == 0 && m_pend == 0), 1);
  endtask

  always @(negedge CLK) begin
    check("host_stop", host_stop, m_stop);
    check("mem_req_valid", mem_req_valid, (m_cnt != 0));
    check("err_status", err_status, m_err);
    check("host_rdata", host_rdata, m_rdata);
    if (mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        check("req_unexpected", 1, 0);
      end else begin
        mon_e = exp_req.pop_front();
        check("req_we", mem_req_we, mon_e.we);
        check("req_addr", mem_req_addr, mon_e.addr);
        check("req_wdata", mem_req_wdata, mon_e.wdata);
        if (!mem_req_we) mem_out++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic        rd, wr, rv, clr;
    logic [63:0] addr;
    int          kind;

    // Reset state and release
    #1 rst_L = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_stop", host_stop, 1);
    check("rst_valid", mem_req_valid, 0);
    check("rst_err", err_status, 0);
    check("rst_rdata", host_rdata, 0);
    rst_L = 1'b1;
    idle(1, 1);
    check("rel_stop", host_stop, 0);

    // Single write
    step(0, 1, 64'h1000, 32'hDEADBEEF, 1, 0, 32'd0, 0);
    check("wr_valid", mem_req_valid, 1);
    check("wr_we", mem_req_we, 1);
    check("wr_addr", mem_req_addr, 32'h1000);
    check("wr_wdata", mem_req_wdata, 32'hDEADBEEF);
    idle(1, 1);
    check("wr_one_cycle", mem_req_valid, 0);

    // Single read with 5-clock response latency
    step(1, 0, 64'h20, 32'h5555_5555, 1, 0, 32'd0, 0);
    check("rd_stop_rise", host_stop, 1);
    idle(4, 1);
    check("rd_stop_hold", host_stop, 1);
    mem_out--;
    step(0, 0, 64'd0, 32'd0, 1, 1, 32'h12345678, 0);
    check("rd_stop_fall", host_stop, 0);
    check("rd_data", host_rdata, 32'h12345678);

    // Backpressure and overflow
    for (int i = 0; i < 3; i++) step(0, 1, 64'h100 + 64'(4 * i), 32'hA000_0000 + i, 0, 0, 32'd0, 0);
    check("bp_stop_after3", host_stop, 1);
    step(0, 1, 64'h10C, 32'hA000_0003, 0, 0, 32'd0, 0);
    check("bp_4th_no_err", err_status, 0);
    step(0, 1, 64'h110, 32'hA000_0004, 0, 0, 32'd0, 0);
    check("bp_5th_overflow", err_status[2], 1);
    drain();
    step(0, 0, 64'd0, 32'd0, 1, 0, 32'd0, 1);
    check("bp_clr", err_status, 0);

    // Error flags; nothing may reach memory
    step(1, 1, 64'h40, 32'h1, 1, 0, 32'd0, 0);
    check("err_rdwr", err_status, 4'b0001);
    step(0, 1, 64'h1_0000_0000, 32'h2, 1, 0, 32'd0, 0);
    check("err_range", err_status, 4'b0011);
    step(0, 0, 64'd0, 32'd0, 1, 1, 32'hBAD0_BAD0, 0);
    check("err_stray", err_status, 4'b1011);
    check("err_stray_rdata", host_rdata, 32'h12345678);
    check("err_no_req", mem_req_valid, 0);
    step(1, 1, 64'h40, 32'h1, 1, 0, 32'd0, 1);
    check("err_clr_set_wins", err_status, 4'b0001);
    step(0, 0, 64'd0, 32'd0, 1, 0, 32'd0, 1);
    check("err_clr", err_status, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rd = 0; wr = 0; rv = 0; addr = 64'($urandom);
      if ((!m_stop || $urandom_range(0, 9) == 0) && $urandom_range(0, 1) == 1) begin
        kind = $urandom_range(0, 15);
        if (kind == 0) begin
          rd = 1; wr = 1;
        end else if (kind == 1) begin
          wr = $urandom_range(0, 1); rd = !wr;
          addr[63:32] = $urandom | 32'h1;
        end else begin
          wr = $urandom_range(0, 1); rd = !wr;
        end
      end
      if (mem_out > 0 && $urandom_range(0, 2) == 0) begin
        rv = 1; mem_out--;
      end else if (m_pend == 0 && $urandom_range(0, 24) == 0) begin
        rv = 1;
      end
      clr = ($urandom_range(0, 29) == 0);
      step(rd, wr, addr, $urandom, ($urandom_range(0, 3) != 0), rv, $urandom, clr);
    end
    drain();

    // Reset with two queued requests
    step(0, 1, 64'h200, 32'h1111, 0, 0, 32'd0, 0);
    step(0, 1, 64'h204, 32'h2222, 0, 0, 32'd0, 0);
    check("mid_queued", mem_req_valid, 1);
    rst_L = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", mem_req_valid, 0);
    check("mid_rst_stop", host_stop, 1);
    repeat (2) @(posedge CLK);
    #1 rst_L = 1'b1;
    idle(1, 1);
    check("mid_rel_valid", mem_req_valid, 0);
    check("mid_rel_stop", host_stop, 0);
    idle(2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
